// File: rtl/game_arb_pkg.sv
// game_arb_pkg: shared types and defaults for the map read-port arbiter and its neighbours
package game_arb_pkg;
    localparam int N_REQ_DEF  = 4;
    localparam int RD_LAT_DEF = 1;
    typedef logic [$clog2(N_REQ_DEF)-1:0] req_id_t;
    typedef enum logic {ARB, LOCKED} arb_state_t;
    function automatic int cnt_w(input int max_lock);
        return ($clog2(max_lock + 1) > 3) ? $clog2(max_lock + 1) : 3;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker starting just after last_grant
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_grant,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any
);
    function automatic logic [ID_W-1:0] wrap(input int v);
        return ID_W'(v % N);
    endfunction
    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any && req[wrap(int'(last_grant) + k)]) begin
                grant[wrap(int'(last_grant) + k)] = 1'b1;
                grant_id = wrap(int'(last_grant) + k);
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/map_port_arbiter.sv
// map_port_arbiter: round-robin sharing of the map ROM read port with short locks and tag-routed responses
module map_port_arbiter
    import game_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 4,
    parameter int RD_LAT   = RD_LAT_DEF,
    parameter int MAX_LOCK = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        lock,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    mem_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_data
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = cnt_w(MAX_LOCK);
    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d, last_grant_q, last_grant_d, pick_id, gid;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [N_REQ-1:0]  pick_grant, rsp_valid_q, rsp_valid_d;
    logic              pick_any, hold, any_ack, mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [RD_LAT:0]   tag_v_q, tag_v_d;
    logic [ID_W-1:0]   tag_id_q [RD_LAT+1];
    logic [ID_W-1:0]   tag_id_d [RD_LAT+1];
    rr_pick #(.N(N_REQ), .ID_W(ID_W)) u_pick (
        .req       (req),
        .last_grant(last_grant_q),
        .grant     (pick_grant),
        .grant_id  (pick_id),
        .any       (pick_any)
    );
    always_comb begin
        // a lock that has run out or been released falls straight through to round-robin
        hold = rst_n && state_q == LOCKED && req[owner_q] && lock[owner_q]
               && lock_cnt_q < CNT_W'(MAX_LOCK);
        any_ack = rst_n && (hold || pick_any);
        gid = hold ? owner_q : pick_id;
        ack = any_ack ? (N_REQ'(1) << gid) : '0;
        state_d    = ARB;
        owner_d    = owner_q;
        lock_cnt_d = '0;
        if (hold) begin
            state_d    = LOCKED;
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end else if (any_ack && lock[pick_id] && MAX_LOCK > 1) begin
            state_d    = LOCKED;
            owner_d    = pick_id;
            lock_cnt_d = CNT_W'(1);
        end
        last_grant_d = any_ack ? gid : last_grant_q;
        mem_en_d     = any_ack;
        mem_addr_d   = any_ack ? req_addr[gid*ADDR_W +: ADDR_W] : mem_addr_q;
        tag_v_d      = {tag_v_q[RD_LAT-1:0], any_ack};
        tag_id_d[0]  = gid;
        for (int i = 1; i <= RD_LAT; i++) tag_id_d[i] = tag_id_q[i-1];
        rsp_valid_d = tag_v_q[RD_LAT] ? (N_REQ'(1) << tag_id_q[RD_LAT]) : '0;
        rsp_data_d  = tag_v_q[RD_LAT] ? mem_data : rsp_data_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB;
            owner_q      <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
            lock_cnt_q   <= '0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            tag_v_q      <= '0;
            tag_id_q     <= '{default: '0};
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            lock_cnt_q   <= lock_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_addr_q   <= mem_addr_d;
            tag_v_q      <= tag_v_d;
            tag_id_q     <= tag_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end
    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_map_port_arbiter.sv
// tb_map_port_arbiter: directed stimulus with a due-cycle scoreboard for memory strobes and responses
module tb_map_port_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  req = '0, lock = '0, ack, rsp_valid, rsp_data, mem_data = '0;
    logic [63:0] req_addr = '0;
    logic        mem_en;
    logic [15:0] mem_addr;
    int          total = 0, bad = 0, cyc = 0;
    typedef struct {int due; logic [3:0] v; logic [15:0] a;} exp_t;
    exp_t        mq[$], rq[$];
    logic [63:0] dflt;
    logic [3:0]  t3 [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                             4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    map_port_arbiter #(.N_REQ(4), .ADDR_W(16), .DATA_W(4), .RD_LAT(1), .MAX_LOCK(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .req_addr(req_addr),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (mem_en) mem_data <= mem_addr[3:0];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] pk(input logic [15:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction
    always @(posedge clk) begin
        cyc++;
        #2;
        if (mq.size() != 0 && mq[0].due == cyc) begin
            chk("mem_en", mem_en, 1);
            chk("mem_addr", mem_addr, mq[0].a);
            void'(mq.pop_front());
        end else chk("mem_idle", mem_en, 0);
        if (rq.size() != 0 && rq[0].due == cyc) begin
            chk("rsp_valid", rsp_valid, rq[0].v);
            chk("rsp_data", rsp_data, rq[0].a);
            void'(rq.pop_front());
        end else chk("rsp_idle", rsp_valid, 0);
    end
    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [3:0] e, input logic [63:0] a);
        @(posedge clk); #1;
        req = r; lock = l; req_addr = a;
        @(negedge clk);
        chk("ack", ack, e);
        for (int i = 0; i < 4; i++) if (e[i]) begin
            mq.push_back('{cyc + 1, e, a[i*16 +: 16]});
            rq.push_back('{cyc + 3, e, {12'h0, a[i*16 +: 4]}});
        end
    endtask
    task automatic idle(input int n);
        repeat (n) step(4'b0000, 4'b0000, 4'b0000, dflt);
    endtask
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; req = 4'b1111; lock = 4'b1111;
        mq.delete(); rq.delete();
        @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        @(posedge clk); #1;
        req = '0; lock = '0; rst_n = 1'b1;
    endtask
    initial begin
        dflt = pk(16'h0109, 16'h020A, 16'h030B, 16'h040C);
        do_reset();
        step(4'b0100, 4'b0000, 4'b0100, pk(16'h0109, 16'h020A, 16'h0105, 16'h040C));
        idle(4);
        do_reset();
        for (int k = 0; k < 8; k++) step(4'b1111, 4'b0000, 4'(1 << (k % 4)), dflt);
        idle(4);
        do_reset();
        for (int k = 0; k < 10; k++) step(4'b0011, 4'b0001, t3[k], dflt);
        idle(4);
        do_reset();
        step(4'b1001, 4'b0001, 4'b0001, dflt);
        step(4'b1001, 4'b0001, 4'b0001, dflt);
        step(4'b1000, 4'b0001, 4'b1000, dflt);
        step(4'b1001, 4'b0000, 4'b0001, dflt);
        step(4'b1001, 4'b0000, 4'b1000, dflt);
        idle(4);
        do_reset();
        step(4'b0111, 4'b0000, 4'b0001, dflt);
        step(4'b0111, 4'b0000, 4'b0010, dflt);
        step(4'b0111, 4'b0000, 4'b0100, dflt);
        do_reset();
        idle(4);
        step(4'b0110, 4'b0000, 4'b0010, dflt);
        idle(4);
        do_reset();
        for (int k = 0; k < 8; k++) step(4'b0010, 4'b0000, 4'b0010, pk(16'h0109, 16'h0010 + 16'(k), 16'h030B, 16'h040C));
        idle(4);
        chk("drain", mq.size() + rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
